// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array skew feeder.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fsm_state_e;

  localparam int K_WIDTH_DEFAULT = 16;

  // Cycles for the last operand to cross the full array diagonal and drain.
  function automatic int flush_len(input int num_rows, input int num_cols, input int pe_latency);
    return num_rows + num_cols - 1 + pe_latency;
  endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Beat-side handshake and array-side skewed lanes of the skew feeder.
interface sa_skew_feeder_if
  import sa_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 32,
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 16,
  parameter int K_WIDTH      = K_WIDTH_DEFAULT
);

  logic                                   start_i;
  logic [K_WIDTH-1:0]                     k_len_i;
  logic                                   s_valid_i;
  logic                                   s_ready_o;
  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   s_input_i;
  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  s_weight_i;
  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   input_o;
  logic [NUM_ROWS-1:0]                    input_valid_o;
  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  weight_o;
  logic [NUM_COLS-1:0]                    weight_valid_o;
  logic                                   busy_o;
  logic                                   tile_done_o;

  modport master (
    output start_i, k_len_i, s_valid_i, s_input_i, s_weight_i,
    input  s_ready_o, input_o, input_valid_o, weight_o, weight_valid_o,
           busy_o, tile_done_o
  );

  modport slave (
    input  start_i, k_len_i, s_valid_i, s_input_i, s_weight_i,
    output s_ready_o, input_o, input_valid_o, weight_o, weight_valid_o,
           busy_o, tile_done_o
  );

endinterface

// File: rtl/sa_delay_line.sv
// Data+valid shift register for one skew lane; stage 0 is the entry register.
module sa_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;

  always_comb begin
    data_d  = '0;
    valid_d = '0;
    // Invalid slots carry zero so the array never sees a stale word.
    data_d[0]  = valid_i ? data_i : '0;
    valid_d[0] = valid_i;
    for (int s = 1; s < DEPTH; s++) begin
      data_d[s]  = data_q[s-1];
      valid_d[s] = valid_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Tile sequencer plus triangular skew of activation rows and weight columns.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 32,
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 16,
  parameter int K_WIDTH      = K_WIDTH_DEFAULT,
  parameter int PE_LATENCY   = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  sa_skew_feeder_if.slave  bus
);

  localparam int FLUSH_LEN = flush_len(NUM_ROWS, NUM_COLS, PE_LATENCY);
  localparam int FCW       = $clog2(FLUSH_LEN + 1);

  fsm_state_e         state_q, state_d;
  logic [K_WIDTH-1:0] k_last_q, k_last_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [FCW-1:0]     flush_q, flush_d;
  logic               done_q, done_d;
  logic               ready;
  logic               beat_acc;

  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]  row_data;
  logic [NUM_ROWS-1:0]                   row_vld;
  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0] col_data;
  logic [NUM_COLS-1:0]                   col_vld;

  assign beat_acc = bus.s_valid_i && ready;

  always_comb begin
    state_d  = state_q;
    k_last_d = k_last_q;
    beat_d   = beat_q;
    flush_d  = flush_q;
    done_d   = 1'b0;
    ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.k_len_i != '0) begin
            // Compare against k_len-1 so the maximum length never wraps.
            k_last_d = bus.k_len_i - K_WIDTH'(1);
            beat_d   = '0;
            state_d  = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        ready = 1'b1;
        if (beat_acc) begin
          if (beat_q == k_last_q) begin
            flush_d = '0;
            state_d = FLUSH;
          end else begin
            beat_d = beat_q + K_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == FCW'(FLUSH_LEN - 1)) begin
          flush_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          flush_d = flush_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_last_q <= '0;
      beat_q   <= '0;
      flush_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_last_q <= k_last_d;
      beat_q   <= beat_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
    end
  end

  // Lane i gets i+1 stages so operands meet on the array's anti-diagonals.
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    sa_delay_line #(
      .DEPTH (i + 1),
      .WIDTH (INPUT_WIDTH)
    ) u_dl (
      .clk_i   (clk_i),
      .clr_n_i (rst_n),
      .data_i  (bus.s_input_i[i]),
      .valid_i (beat_acc),
      .data_o  (row_data[i]),
      .valid_o (row_vld[i])
    );
  end

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    sa_delay_line #(
      .DEPTH (j + 1),
      .WIDTH (WEIGHT_WIDTH)
    ) u_dl (
      .clk_i   (clk_i),
      .clr_n_i (rst_n),
      .data_i  (bus.s_weight_i[j]),
      .valid_i (beat_acc),
      .data_o  (col_data[j]),
      .valid_o (col_vld[j])
    );
  end

  assign bus.s_ready_o      = ready;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.tile_done_o    = done_q;
  assign bus.input_o        = row_data;
  assign bus.input_valid_o  = row_vld;
  assign bus.weight_o       = col_data;
  assign bus.weight_valid_o = col_vld;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder on a 4x4 array (flush length 8).
module tb_sa_skew_feeder;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int IW = 32;
  localparam int WW = 32;
  localparam int KW = 16;
  localparam int PL = 1;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_skew_feeder_if #(
    .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .NUM_ROWS(NR), .NUM_COLS(NC), .K_WIDTH(KW)
  ) bus ();

  sa_skew_feeder #(
    .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .NUM_ROWS(NR), .NUM_COLS(NC),
    .K_WIDTH(KW), .PE_LATENCY(PL)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t row_q[NR][$];
  exp_t col_q[NC][$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation whenever a lane or tile_done_o presents.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   d;
    if (mon_en) begin
      for (int i = 0; i < NR; i++) begin
        checks++;
        if (bus.input_valid_o[i]) begin
          if (row_q[i].size() == 0) begin
            errors++;
            $display("FAIL row%0d_unexpected got=%0d cyc=%0d", i, bus.input_o[i], cyc);
          end else begin
            e = row_q[i].pop_front();
            if (bus.input_o[i] !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL row%0d_beat got=%0d@%0d exp=%0d@%0d", i, bus.input_o[i], cyc, e.data, e.cyc);
            end
          end
        end else if (bus.input_o[i] !== '0) begin
          errors++;
          $display("FAIL row%0d_zero got=%0d exp=0 cyc=%0d", i, bus.input_o[i], cyc);
        end
      end
      for (int j = 0; j < NC; j++) begin
        checks++;
        if (bus.weight_valid_o[j]) begin
          if (col_q[j].size() == 0) begin
            errors++;
            $display("FAIL col%0d_unexpected got=%0d cyc=%0d", j, bus.weight_o[j], cyc);
          end else begin
            e = col_q[j].pop_front();
            if (bus.weight_o[j] !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL col%0d_beat got=%0d@%0d exp=%0d@%0d", j, bus.weight_o[j], cyc, e.data, e.cyc);
            end
          end
        end else if (bus.weight_o[j] !== '0) begin
          errors++;
          $display("FAIL col%0d_zero got=%0d exp=0 cyc=%0d", j, bus.weight_o[j], cyc);
        end
      end
      if (bus.tile_done_o) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL tile_done_unexpected cyc=%0d", cyc);
        end else begin
          d = done_q.pop_front();
          if (d != cyc) begin
            errors++;
            $display("FAIL tile_done_cycle got=%0d exp=%0d", cyc, d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) row_q[i].delete();
    for (int j = 0; j < NC; j++) col_q[j].delete();
    done_q.delete();
  endtask

  task automatic do_start(input int k);
    bus.start_i = 1'b1;
    bus.k_len_i = KW'(k);
    tick();
    bus.start_i = 1'b0;
    bus.k_len_i = '0;
  endtask

  // Beat b carries activations 4b+1..4b+4 and weights 100+4b+1..100+4b+4.
  task automatic beat(input int b, input bit v, input bit last);
    for (int i = 0; i < NR; i++) bus.s_input_i[i] = 32'(4 * b + i + 1);
    for (int j = 0; j < NC; j++) bus.s_weight_i[j] = 32'(100 + 4 * b + j + 1);
    bus.s_valid_i = v;
    if (v) begin
      for (int i = 0; i < NR; i++) row_q[i].push_back('{data: 32'(4 * b + i + 1), cyc: cyc + 1 + i});
      for (int j = 0; j < NC; j++) col_q[j].push_back('{data: 32'(100 + 4 * b + j + 1), cyc: cyc + 1 + j});
      if (last) done_q.push_back(cyc + 1 + FL);
    end
    tick();
    bus.s_valid_i = 1'b0;
  endtask

  // Entered in the first FLUSH cycle; returns in the tile_done_o cycle.
  task automatic flush_watch(input bit poke);
    for (int j = 0; j < FL; j++) begin
      chk("ready_flush", 32'(bus.s_ready_o), 32'd0);
      chk("busy_flush", 32'(bus.busy_o), 32'd1);
      if (poke && j == 3) begin
        bus.start_i = 1'b1;
        bus.k_len_i = KW'(2);
      end
      tick();
      bus.start_i = 1'b0;
      bus.k_len_i = '0;
    end
    chk("busy_done", 32'(bus.busy_o), 32'd0);
    chk("ready_done", 32'(bus.s_ready_o), 32'd0);
  endtask

  task automatic run_tile(input int k, input logic [7:0] bubble, input bit poke);
    int b;
    int slot;
    bit v;
    do_start(k);
    chk("busy_start", 32'(bus.busy_o), 32'd1);
    b = 0;
    slot = 0;
    while (b < k) begin
      chk("ready_stream", 32'(bus.s_ready_o), 32'd1);
      v = !bubble[slot];
      beat(b, v, v && (b == k - 1));
      if (v) b++;
      slot++;
    end
    flush_watch(poke);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.k_len_i    = '0;
    bus.s_valid_i  = 1'b0;
    bus.s_input_i  = '0;
    bus.s_weight_i = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.s_ready_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.tile_done_o), 32'd0);
    chk("rst_in_vld", 32'(bus.input_valid_o), 32'd0);
    chk("rst_wt_vld", 32'(bus.weight_valid_o), 32'd0);
    for (int i = 0; i < NR; i++) chk("rst_in_data", bus.input_o[i], 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Reset in the middle of a stream after two beats.
    do_start(4);
    beat(0, 1'b1, 1'b0);
    beat(1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    clear_queues();
    chk("midrst_in_vld", 32'(bus.input_valid_o), 32'd0);
    chk("midrst_wt_vld", 32'(bus.weight_valid_o), 32'd0);
    chk("midrst_ready", 32'(bus.s_ready_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain 3-beat tile, then the same tile with a bubble in the 2nd slot.
    run_tile(3, 8'b0000_0000, 1'b0);
    tick();
    run_tile(3, 8'b0000_0010, 1'b0);
    tick();

    // Zero-length tile completes immediately without opening the stream.
    done_q.push_back(cyc + 1);
    do_start(0);
    chk("k0_ready", 32'(bus.s_ready_o), 32'd0);
    chk("k0_busy", 32'(bus.busy_o), 32'd0);
    tick();
    chk("k0_ready_after", 32'(bus.s_ready_o), 32'd0);
    tick();

    // start_i during FLUSH must be ignored.
    run_tile(3, 8'b0000_0000, 1'b1);
    tick();
    chk("poke_idle_busy", 32'(bus.busy_o), 32'd0);
    tick();

    // Back-to-back: second start issued in the first tile_done_o cycle.
    run_tile(2, 8'b0000_0000, 1'b0);
    run_tile(1, 8'b0000_0000, 1'b0);
    repeat (12) tick();

    for (int i = 0; i < NR; i++) chk("row_q_drained", 32'(row_q[i].size()), 32'd0);
    for (int j = 0; j < NC; j++) chk("col_q_drained", 32'(col_q[j].size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
